// File: rtl/snn_tile_scheduler.sv
// Tile scheduler for SNN_Core: for each 16x16 tile it pulses the core start, streams the pixels
// from the external RAM, then collects the core results tagged with the tile index.
module snn_tile_scheduler #(
    parameter int IMAGE_WIDTH  = 16,
    parameter int ADDR_W       = 16,
    parameter int RES_PER_TILE = 1,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iCmdValid,
    output logic              oCmdReady,
    input  logic [ADDR_W-1:0] iBaseAddr,
    input  logic [7:0]        iNumTiles,
    input  logic              iAbort,
    output logic              oMemRdEn,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic [7:0]        iMemRdData,
    output logic              oCoreStart,
    output logic [7:0]        oCoreData,
    output logic              oCoreValid,
    input  logic [7:0]        iCoreResult,
    input  logic              iCoreValid,
    output logic              oResValid,
    output logic [7:0]        oResData,
    output logic [7:0]        oResTile,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErrTimeout
);

    localparam int PIXEL_COUNT = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int PCNT_W      = $clog2(PIXEL_COUNT + 1);
    localparam int RCNT_W      = $clog2(RES_PER_TILE + 1);
    localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [7:0]        ntiles_q,  ntiles_d;
    logic [7:0]        tile_q,    tile_d;
    logic [PCNT_W-1:0] pcnt_q,    pcnt_d;
    logic [RCNT_W-1:0] rcnt_q,    rcnt_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic              err_q,     err_d;
    logic              vld_q,     vld_d;
    logic              resvld_q,  resvld_d;
    logic [7:0]        resdata_q, resdata_d;
    logic [7:0]        restile_q, restile_d;
    logic              res_done;
    logic              tmr_expired;

    assign res_done    = (rcnt_q == RCNT_W'(RES_PER_TILE));
    assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        ntiles_d  = ntiles_q;
        tile_d    = tile_q;
        pcnt_d    = pcnt_q;
        rcnt_d    = rcnt_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        vld_d     = 1'b0;
        resvld_d  = 1'b0;
        resdata_d = resdata_q;
        restile_d = restile_q;

        // Results are tagged with the tile being processed when the core reports them
        if (state_q != S_IDLE && iCoreValid) begin
            resvld_d  = 1'b1;
            resdata_d = iCoreResult;
            restile_d = tile_q;
            if (!res_done) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (iCmdValid) begin
                    base_d   = iBaseAddr;
                    ntiles_d = iNumTiles;
                    tile_d   = '0;
                    err_d    = 1'b0;
                    state_d  = (iNumTiles == 8'd0) ? S_FINISH : S_START;
                end
            end
            S_START: begin
                pcnt_d  = '0;
                rcnt_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                vld_d  = 1'b1;
                pcnt_d = pcnt_q + 1'b1;
                if (pcnt_q == PCNT_W'(PIXEL_COUNT - 1)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (res_done || tmr_expired) begin
                    if (!res_done) begin
                        err_d = 1'b1;
                    end
                    tile_d  = tile_q + 1'b1;
                    state_d = (tile_q + 1'b1 == ntiles_q) ? S_FINISH : S_START;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the pixel still in flight from the RAM
        if (state_q != S_IDLE && iAbort) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            ntiles_q  <= '0;
            tile_q    <= '0;
            pcnt_q    <= '0;
            rcnt_q    <= '0;
            tmr_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            resvld_q  <= 1'b0;
            resdata_q <= '0;
            restile_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            ntiles_q  <= ntiles_d;
            tile_q    <= tile_d;
            pcnt_q    <= pcnt_d;
            rcnt_q    <= rcnt_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            resvld_q  <= resvld_d;
            resdata_q <= resdata_d;
            restile_q <= restile_d;
        end
    end

    // The RAM registers its read data, so pixel data lines up with the registered rdEn
    assign oCmdReady   = (state_q == S_IDLE);
    assign oBusy       = (state_q != S_IDLE);
    assign oCoreStart  = (state_q == S_START) && !iAbort;
    assign oMemRdEn    = (state_q == S_STREAM) && !iAbort;
    assign oMemAddr    = oMemRdEn
                       ? base_q + ADDR_W'(tile_q) * ADDR_W'(PIXEL_COUNT) + ADDR_W'(pcnt_q)
                       : '0;
    assign oCoreValid  = vld_q && !iAbort;
    assign oCoreData   = oCoreValid ? iMemRdData : 8'h00;
    assign oDone       = (state_q == S_FINISH) && !iAbort;
    assign oResValid   = resvld_q;
    assign oResData    = resdata_q;
    assign oResTile    = restile_q;
    assign oErrTimeout = err_q;

endmodule

// File: tb/tb_snn_tile_scheduler.sv
// Directed bench for snn_tile_scheduler with a pixel RAM model (RAM[i]=i[7:0]) and a simple
// core model answering 0xA5 some cycles after the last pixel of each tile.
module tb_snn_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] base_addr;
    logic [7:0]  num_tiles;
    logic        abort;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        core_start;
    logic [7:0]  core_data;
    logic        core_valid;
    logic [7:0]  core_result;
    logic        core_res_valid;
    logic        res_valid;
    logic [7:0]  res_data_o;
    logic [7:0]  res_tile_o;
    logic        busy;
    logic        done;
    logic        err_timeout;

    always #5 clk = ~clk;

    snn_tile_scheduler dut (
        .iClk        (clk),
        .iRst        (rst_n),
        .iCmdValid   (cmd_valid),
        .oCmdReady   (cmd_ready),
        .iBaseAddr   (base_addr),
        .iNumTiles   (num_tiles),
        .iAbort      (abort),
        .oMemRdEn    (mem_rd_en),
        .oMemAddr    (mem_addr),
        .iMemRdData  (mem_rd_data),
        .oCoreStart  (core_start),
        .oCoreData   (core_data),
        .oCoreValid  (core_valid),
        .iCoreResult (core_result),
        .iCoreValid  (core_res_valid),
        .oResValid   (res_valid),
        .oResData    (res_data_o),
        .oResTile    (res_tile_o),
        .oBusy       (busy),
        .oDone       (done),
        .oErrTimeout (err_timeout)
    );

    // Pixel RAM: one-cycle read latency, contents equal to the low address byte
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) if (mem_rd_en) ram_q <= mem_addr[7:0];
    assign mem_rd_data = ram_q;

    // Core model: answers 0xA5 about 20 cycles after the 256th pixel of a tile
    logic       core_en = 1'b1;
    logic       force_vld = 1'b0;
    logic       model_vld = 1'b0;
    int         tile_pix = 0;
    int         resp_cd = 0;
    always @(posedge clk) begin
        model_vld <= 1'b0;
        if (core_start) tile_pix <= 0;
        if (core_valid) begin
            tile_pix <= tile_pix + 1;
            if (tile_pix == 255 && core_en) resp_cd <= 20;
        end else if (resp_cd != 0) begin
            resp_cd <= resp_cd - 1;
            if (resp_cd == 1) model_vld <= 1'b1;
        end
    end
    assign core_res_valid = model_vld | force_vld;
    assign core_result    = 8'hA5;

    // Per-command activity monitor, restarted on every accepted command
    logic [15:0] base_m = 16'h0;
    logic [15:0] last_addr = 16'h0;
    int n_rd = 0, n_valid = 0, n_start = 0, n_done = 0, n_res = 0;
    int addr_err = 0, data_err = 0, wrap_at = -1, cyc = 0, done_cyc = -1;
    logic [7:0] res_tile [0:7];
    logic [7:0] res_data [0:7];

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            base_m   <= base_addr;
            n_rd     <= 0;
            n_valid  <= 0;
            n_start  <= 0;
            n_done   <= 0;
            n_res    <= 0;
            addr_err <= 0;
            data_err <= 0;
            wrap_at  <= -1;
            cyc      <= 1;
            done_cyc <= -1;
        end else begin
            cyc <= cyc + 1;
            if (mem_rd_en) begin
                if (mem_addr !== base_m + 16'(n_rd)) addr_err <= addr_err + 1;
                if (mem_addr == 16'h0000 && wrap_at < 0) wrap_at <= n_rd;
                last_addr <= mem_addr;
                n_rd <= n_rd + 1;
            end
            if (core_valid) begin
                if (core_data !== 8'(base_m + 16'(n_valid))) data_err <= data_err + 1;
                n_valid <= n_valid + 1;
            end
            if (core_start) n_start <= n_start + 1;
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (res_valid && n_res < 8) begin
                res_tile[n_res] <= res_tile_o;
                res_data[n_res] <= res_data_o;
                n_res <= n_res + 1;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [15:0] b, input logic [7:0] n);
        cmd_valid = 1'b1;
        base_addr = b;
        num_tiles = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
    endtask

    task automatic wait_rd(input int n, input int budget);
        for (int i = 0; i < budget && n_rd < n; i++) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        base_addr = 16'h0;
        num_tiles = 8'h0;
        abort     = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_rden",  32'(mem_rd_en), 0);
        chk("rst_start", 32'(core_start), 0);
        chk("rst_err",   32'(err_timeout), 0);
        rst_n = 1'b1;
        tick();

        // Single tile with core response
        cmd(16'h0000, 8'd1);
        chk("t1_busy", 32'(busy), 1);
        wait_done(1000);
        chk("t1_done",    32'(n_done), 1);
        chk("t1_start",   32'(n_start), 1);
        chk("t1_nvalid",  32'(n_valid), 256);
        chk("t1_data",    32'(data_err), 0);
        chk("t1_nres",    32'(n_res), 1);
        chk("t1_resdata", 32'(res_data[0]), 32'hA5);
        chk("t1_restile", 32'(res_tile[0]), 0);
        chk("t1_noerr",   32'(err_timeout), 0);
        tick();
        chk("t1_idle", 32'(cmd_ready), 1);
        chk("t1_pulse", 32'(done), 0);

        // Three contiguous tiles
        cmd(16'h0100, 8'd3);
        wait_done(3000);
        chk("t3_done",   32'(n_done), 1);
        chk("t3_nrd",    32'(n_rd), 768);
        chk("t3_addr",   32'(addr_err), 0);
        chk("t3_last",   32'(last_addr), 32'h03FF);
        chk("t3_start",  32'(n_start), 3);
        chk("t3_data",   32'(data_err), 0);
        chk("t3_nres",   32'(n_res), 3);
        chk("t3_tile0",  32'(res_tile[0]), 0);
        chk("t3_tile1",  32'(res_tile[1]), 1);
        chk("t3_tile2",  32'(res_tile[2]), 2);
        tick();

        // Core silent: every WAIT runs the full 64 cycles
        core_en = 1'b0;
        cmd(16'h0000, 8'd2);
        wait_done(3000);
        chk("to_done",   32'(n_done), 1);
        chk("to_cyc",    32'(done_cyc), 643);
        chk("to_err",    32'(err_timeout), 1);
        chk("to_nres",   32'(n_res), 0);
        chk("to_start",  32'(n_start), 2);
        tick();

        // Abort in the second tile after the first one timed out
        cmd(16'h0000, 8'd2);
        chk("ab_errclr", 32'(err_timeout), 0);
        wait_rd(300, 2000);
        chk("ab_reach", 32'(n_rd), 300);
        abort = 1'b1;
        #1;
        chk("ab_rden",  32'(mem_rd_en), 0);
        chk("ab_cvld",  32'(core_valid), 0);
        tick();
        abort = 1'b0;
        chk("ab_idle",  32'(cmd_ready), 1);
        chk("ab_cvld2", 32'(core_valid), 0);
        chk("ab_err",   32'(err_timeout), 1);
        for (int i = 0; i < 400; i++) tick();
        chk("ab_nodone", 32'(n_done), 0);
        core_en = 1'b1;

        // Zero tiles, with abort in IDLE on the same cycle
        abort = 1'b1;
        cmd(16'h1234, 8'd0);
        abort = 1'b0;
        chk("z_busy", 32'(busy), 1);
        chk("z_errclr", 32'(err_timeout), 0);
        tick();
        tick();
        chk("z_done",  32'(n_done), 1);
        chk("z_cyc",   32'(done_cyc), 1);
        chk("z_start", 32'(n_start), 0);
        chk("z_rd",    32'(n_rd), 0);

        // Core valid while IDLE is not forwarded
        force_vld = 1'b1;
        tick();
        force_vld = 1'b0;
        chk("idle_res", 32'(res_valid), 0);
        tick();
        chk("idle_nres", 32'(n_res), 0);

        // Address wrap
        cmd(16'hFF80, 8'd1);
        wait_done(1000);
        chk("w_done",   32'(n_done), 1);
        chk("w_nrd",    32'(n_rd), 256);
        chk("w_wrap",   32'(wrap_at), 128);
        chk("w_last",   32'(last_addr), 32'h007F);
        chk("w_addr",   32'(addr_err), 0);
        chk("w_nvalid", 32'(n_valid), 256);
        chk("w_data",   32'(data_err), 0);
        tick();

        // Reset in the middle of streaming
        cmd(16'h0000, 8'd1);
        wait_rd(100, 500);
        chk("r_reach", 32'(n_rd), 100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r_ready", 32'(cmd_ready), 1);
        chk("r_busy",  32'(busy), 0);
        chk("r_rden",  32'(mem_rd_en), 0);
        chk("r_addr",  32'(mem_addr), 0);
        chk("r_cvld",  32'(core_valid), 0);
        chk("r_cdata", 32'(core_data), 0);
        chk("r_start", 32'(core_start), 0);
        chk("r_resv",  32'(res_valid), 0);
        chk("r_done",  32'(done), 0);
        chk("r_err",   32'(err_timeout), 0);
        for (int i = 0; i < 50; i++) tick();
        chk("r_nodone", 32'(n_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
